// File: rtl/score_display_scanner.sv
// ============================================================================
// Module   : score_display_scanner
// Purpose  : Time-multiplexed scan of a multi-digit score onto one shared
//            seven-segment decoder, with blanking guard and frame-aligned update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_req,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic                    upd_ack,
    output logic                    frame_commit,
    output logic [3:0]              dec_x,
    output logic [NUM_DIGITS-1:0]   digit_en_n
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [VAL_W-1:0]      r_active, w_active_nxt;
    logic [VAL_W-1:0]      r_pending, w_pending_nxt;
    logic                  r_pend_flag, w_pend_flag_nxt;

    logic                  w_cnt_last;
    logic                  w_boundary;
    logic                  w_commit;
    logic                  w_zero_above;
    logic                  w_suppress;
    logic [NUM_DIGITS-1:0] w_lead_zero;
    logic [3:0]            w_dec_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_flag  <= 1'b0;
            upd_ack      <= 1'b0;
            frame_commit <= 1'b0;
            dec_x        <= 4'd0;
            digit_en_n   <= '1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_flag  <= w_pend_flag_nxt;
            upd_ack      <= upd_req;
            frame_commit <= w_commit;
            dec_x        <= w_dec_nxt;
            digit_en_n   <= w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_last      = (r_cnt == CNT_LAST);
        w_boundary      = w_cnt_last && (r_idx == IDX_LAST);
        w_cnt_nxt       = w_cnt_last ? '0 : r_cnt + 1'b1;
        w_idx_nxt       = r_idx;
        w_commit        = w_boundary && (upd_req || r_pend_flag);
        w_active_nxt    = r_active;
        w_pending_nxt   = upd_req ? value_in : r_pending;
        w_pend_flag_nxt = r_pend_flag | upd_req;
        w_zero_above    = 1'b1;
        w_lead_zero     = '0;
        w_suppress      = 1'b0;
        w_dec_nxt       = 4'd0;
        w_en_nxt        = '1;

        case (r_state)
            ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_cnt_last)          w_state_nxt = ST_BLANK;
            default:                           w_state_nxt = ST_BLANK;
        endcase

        if (w_cnt_last) begin
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        // A request landing on the boundary edge bypasses the shadow register.
        if (w_boundary) begin
            w_pend_flag_nxt = 1'b0;
            if (upd_req) begin
                w_active_nxt = value_in;
            end else if (r_pend_flag) begin
                w_active_nxt = r_pending;
            end
        end

        // Digit 0 is never flagged, so an all-zero value still shows one '0'.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above   = w_zero_above & (w_active_nxt[4*i +: 4] == 4'd0);
            w_lead_zero[i] = w_zero_above;
        end

        // Outputs are decoded from next-state so they line up with the counter.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_dec_nxt  = w_active_nxt[4*i +: 4];
                w_suppress = blank_mask[i] | (lz_suppress & w_lead_zero[i]);
                if ((w_state_nxt == ST_DRIVE) && !w_suppress) begin
                    w_en_nxt[i] = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_display_scanner.sv
// ============================================================================
// Module   : tb_score_display_scanner
// Purpose  : Self-checking bench for score_display_scanner against a
//            cycle-indexed arithmetic model of the scan, suppression and commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_display_scanner;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int F  = ND * SD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            upd_req = 1'b0;
    logic [4*ND-1:0] value_in = '0;
    logic [ND-1:0]   blank_mask = '0;
    logic            lz_suppress = 1'b0;
    logic            upd_ack;
    logic            frame_commit;
    logic [3:0]      dec_x;
    logic [ND-1:0]   digit_en_n;

    score_display_scanner #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_req     (upd_req),
        .value_in    (value_in),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .upd_ack     (upd_ack),
        .frame_commit(frame_commit),
        .dec_x       (dec_x),
        .digit_en_n  (digit_en_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // Stimulus for the cycle about to be applied
    logic            req  = 1'b0;
    logic [4*ND-1:0] val  = '0;
    logic [ND-1:0]   mask = '0;
    logic            lz   = 1'b0;

    // Reference model state
    logic [4*ND-1:0] m_active = '0;
    logic [4*ND-1:0] m_pend   = '0;
    logic            m_flag   = 1'b0;
    logic [3:0]      exp_dec  = '0;
    logic [ND-1:0]   exp_en   = '1;
    logic            exp_ack  = 1'b0;
    logic            exp_fc   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Expected display for absolute cycle u of the current run.
    task automatic predict(input int u);
        int  slot;
        int  pos;
        logic sup;
        slot    = (u / SD) % ND;
        pos     = u % SD;
        exp_dec = m_active[4*slot +: 4];
        sup     = mask[slot] || (lz && slot > 0 && (m_active >> (4*slot)) == 0);
        exp_en  = (pos >= BL && !sup) ? ~(ND'(1) << slot) : '1;
    endtask

    task automatic step();
        logic bnd;
        logic fc;
        check("dec_x",        32'(dec_x),        32'(exp_dec));
        check("digit_en_n",   32'(digit_en_n),   32'(exp_en));
        check("upd_ack",      32'(upd_ack),      32'(exp_ack));
        check("frame_commit", 32'(frame_commit), 32'(exp_fc));
        upd_req     = req;
        value_in    = val;
        blank_mask  = mask;
        lz_suppress = lz;
        bnd = ((t % F) == F - 1);
        fc  = 1'b0;
        if (bnd && (req || m_flag)) begin
            m_active = req ? val : m_pend;
            m_flag   = 1'b0;
            fc       = 1'b1;
        end
        if (req) begin
            m_pend = val;
            if (!bnd) m_flag = 1'b1;
        end
        exp_ack = req;
        exp_fc  = fc;
        predict(t + 1);
        t++;
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int m);
        while ((t % F) != m) step();
    endtask

    task automatic do_reset();
        req     = 1'b0;
        upd_req = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        t        = 0;
        m_active = '0;
        m_pend   = '0;
        m_flag   = 1'b0;
        exp_dec  = '0;
        exp_en   = '1;
        exp_ack  = 1'b0;
        exp_fc   = 1'b0;
    endtask

    task automatic post(input logic [4*ND-1:0] v);
        req = 1'b1;
        val = v;
        step();
    endtask

    initial begin
        do_reset();

        // Plain scan, then a mid-frame update that must wait for the boundary
        run_to(5); post(16'h1234); run(60);
        run_to(5); post(16'h0042); run_to(0); run(F);

        // Leading-zero suppression on and off, including the all-zero value
        lz = 1'b1; run(F);
        run_to(5); post(16'h0000); run_to(0); run(F);
        lz = 1'b0; run(F);

        // Forced blanking of one digit
        mask = 4'b0100;
        run_to(5); post(16'h1234); run_to(0); run(F);
        mask = 4'b0000;

        // Request on the boundary edge, then a burst of requests in one frame
        run_to(F - 1); post(16'h5678); run(2 * F);
        run_to(3); post(16'hAAAA); post(16'hBEEF); post(16'h9C0D);
        run_to(0); run(F);

        // Asynchronous reset during digit 2 drive with an update pending
        run_to(9); post(16'h4321);
        run_to(20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst dec_x",        32'(dec_x),        32'h0);
        check("async_rst digit_en_n",   32'(digit_en_n),   32'(4'hF));
        check("async_rst upd_ack",      32'(upd_ack),      32'h0);
        check("async_rst frame_commit", 32'(frame_commit), 32'h0);
        do_reset();
        run(2 * F);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            req = ($urandom % 5) == 0;
            val = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if (($urandom % 40) == 0) mask = ND'($urandom);
            if (($urandom % 40) == 0) mask = '0;
            if (($urandom % 30) == 0) lz = ~lz;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_display_scanner.md
Name: score_display_scanner

Overview:
Time-multiplexes a multi-digit score value onto a single shared hex-to-seven-segment decoder. The block drives the decoder's 4-bit digit code and the active-low digit enables of a common-segment display. It inserts a blanking guard between digits to prevent ghosting and performs optional leading-zero suppression. New score values arrive through a request/ack handshake into a shadow register and are committed only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8).
SCAN_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, guard cycles at the start of each slot with all enables off; must be at least 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
upd_req  input  1  request to load value_in.
value_in  input  4*NUM_DIGITS  new value, one nibble per digit; nibble 0 (LSBs) is the rightmost digit.
blank_mask  input  NUM_DIGITS  1 forces that digit dark; sampled live.
lz_suppress  input  1  1 enables leading-zero blanking; sampled live.
upd_ack  output  1  one-cycle pulse: value_in captured.
frame_commit  output  1  one-cycle pulse: pending value became active.
dec_x  output  4  digit code to the shared decoder.
digit_en_n  output  NUM_DIGITS  active-low digit enables, one-hot-low or all high.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - dec_x=0, digit_en_n=all 1, upd_ack=0, frame_commit=0.
  - Active register=0, pending register=0, pending flag=0.
  - Slot counter=0, digit index=0, FSM=BLANK.
- Reset asserted mid-slot forces the reset values immediately. No partial commit survives reset.
- Cycle numbering: cycle 0 is the first rising edge after rst_n deasserts.
- FSM states:
  - BLANK: slot counter runs 0..BLANK_CYCLES-1; digit_en_n is all 1.
  - DRIVE: slot counter runs BLANK_CYCLES..SCAN_DIV-1; the current digit's enable is low unless that digit is suppressed.
  - At slot counter SCAN_DIV-1: the counter wraps to 0, the digit index increments, and the FSM returns to BLANK.
- Digit index NUM_DIGITS-1 wraps to 0; this wrap is the frame boundary.
- Digit slot timing: digit i is driven during cycles f*F + i*SCAN_DIV + BLANK_CYCLES through f*F + (i+1)*SCAN_DIV - 1, where F = NUM_DIGITS*SCAN_DIV and f is the frame number.
- dec_x holds the current digit's active nibble for the whole slot, including BLANK, so the decoder settles before the enable asserts.
- Suppression:
  - A digit is suppressed if its blank_mask bit is 1, OR lz_suppress=1 and it is a leading zero.
  - Leading zero: its nibble and every more-significant nibble are 0.
  - Digit 0 is never a leading zero, so value 0 displays a single "0".
  - A suppressed digit keeps digit_en_n all 1 for the whole slot; dec_x still follows its nibble.
- Update handshake:
  - When upd_req=1, value_in is captured into the pending register at that edge and the pending flag is set.
  - upd_ack pulses in the following cycle.
  - Back-to-back requests are legal; the latest captured value wins.
  - Capture never stalls and is independent of the scan FSM.
- Commit:
  - At the frame-boundary edge, if the pending flag is set, pending copies to active and the flag clears.
  - frame_commit pulses in the first cycle of the new frame, which is digit 0 in BLANK.
- Simultaneous capture and commit at the same edge: the value on value_in at that edge is committed (pass-through), the flag ends clear, upd_ack and frame_commit both pulse in the next cycle.
- Active-register values are never modified mid-frame.
- Nibbles 0xA–0xF are passed through to dec_x unchanged; only leading-zero logic treats 0 specially.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 (F=32) unless noted.
1. Reset scan: hold value 0x1234, lz_suppress=0, mask=0 -> digit_en_n=1110 in cycles 2–7, 1101 in 10–15, 1011 in 18–23, 0111 in 26–31, all 1 in 0–1, 8–9, 16–17, 24–25; dec_x=4,3,2,1 per slot; repeats from cycle 32.
2. Update timing: upd_req pulse with 0x0042 at cycle 5 -> upd_ack=1 at cycle 6; display unchanged through cycle 31; frame_commit=1 at cycle 32; slot 0 shows dec_x=2 from cycle 32.
3. Leading zeros: active 0x0042, lz_suppress=1 -> digits 0–1 enabled, digits 2–3 stay all 1; value 0x0000 -> only digit 0 enabled with dec_x=0; lz_suppress=0 -> all four enabled.
4. Blank mask: blank_mask=0100 with 0x1234 -> digit 2 never enabled, dec_x=2 during its slot; others normal.
5. Boundary race: upd_req with 0x5678 exactly at the frame-boundary edge -> frame_commit and upd_ack both pulse the next cycle, new frame shows 8,7,6,5, pending flag clear (no second commit at the following boundary); repeated requests at cycles 3, 4, 5 -> only the cycle-5 value displayed after the boundary.
6. Reset mid-operation: assert rst_n=0 during digit 2 DRIVE with a pending update -> digit_en_n all 1 and dec_x=0 immediately (asynchronously); after release the scan restarts at digit 0 with active=0 and no frame_commit pulse.
